// File: rtl/mem_switch.sv
// Fixed-priority memory arbiter (dcache > icache > prefetch) that remembers which
// requester owns each outstanding load tag and routes completing tags back to it.
package mem_switch_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    OWN_FREE   = 2'd0,
    OWN_DCACHE = 2'd1,
    OWN_ICACHE = 2'd2,
    OWN_PREF   = 2'd3
  } owner_t;
endpackage

module mem_switch
  import mem_switch_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      dcache2mem_command,
  input  logic [XLEN-1:0] dcache2mem_addr,
  input  logic [63:0]     dcache2mem_data,
  input  logic [1:0]      icache2mem_command,
  input  logic [XLEN-1:0] icache2mem_addr,
  input  logic [1:0]      pref2mem_command,
  input  logic [XLEN-1:0] pref2mem_addr,
  input  logic [3:0]      mem2proc_response,
  input  logic [3:0]      mem2proc_tag,
  input  logic [63:0]     mem2proc_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2dcache_response,
  output logic [3:0]      mem2icache_response,
  output logic [3:0]      mem2pref_response,
  output logic [3:0]      mem2dcache_tag,
  output logic [3:0]      mem2icache_tag,
  output logic [3:0]      mem2pref_tag,
  output logic [63:0]     mem2cache_data,
  output logic            give_way,
  output logic [3:0]      dcache_outstanding,
  output logic [3:0]      icache_outstanding,
  output logic [3:0]      pref_outstanding
);

  owner_t owner [16];
  owner_t grant;
  owner_t retire_owner;
  logic   alloc;

  always_comb begin
    grant            = OWN_FREE;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (dcache2mem_command != BUS_NONE) begin
      grant            = OWN_DCACHE;
      proc2mem_command = dcache2mem_command;
      proc2mem_addr    = dcache2mem_addr;
      proc2mem_data    = dcache2mem_data;
    end else if (icache2mem_command != BUS_NONE) begin
      grant            = OWN_ICACHE;
      proc2mem_command = icache2mem_command;
      proc2mem_addr    = icache2mem_addr;
    end else if (pref2mem_command != BUS_NONE) begin
      grant            = OWN_PREF;
      proc2mem_command = pref2mem_command;
      proc2mem_addr    = pref2mem_addr;
    end
  end

  assign mem2dcache_response = (grant == OWN_DCACHE) ? mem2proc_response : 4'd0;
  assign mem2icache_response = (grant == OWN_ICACHE) ? mem2proc_response : 4'd0;
  assign mem2pref_response   = (grant == OWN_PREF)   ? mem2proc_response : 4'd0;

  assign give_way = (pref2mem_command != BUS_NONE) &&
                    ((grant == OWN_DCACHE) || (grant == OWN_ICACHE));

  // Stores never come back with data, so only accepted loads claim a tag.
  assign alloc        = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);
  assign retire_owner = (mem2proc_tag != 4'd0) ? owner[mem2proc_tag] : OWN_FREE;

  assign mem2dcache_tag = (retire_owner == OWN_DCACHE) ? mem2proc_tag : 4'd0;
  assign mem2icache_tag = (retire_owner == OWN_ICACHE) ? mem2proc_tag : 4'd0;
  assign mem2pref_tag   = (retire_owner == OWN_PREF)   ? mem2proc_tag : 4'd0;
  assign mem2cache_data = mem2proc_data;

  function automatic logic [3:0] next_count(input logic [3:0] cnt,
                                            input logic inc, input logic dec);
    logic [3:0] result;
    result = cnt;
    if (inc && !dec && cnt != 4'd15)
      result = cnt + 4'd1;
    else if (dec && !inc && cnt != 4'd0)
      result = cnt - 4'd1;
    return result;
  endfunction

  // Allocation is written after the free so a reused tag keeps its new owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 16; k++)
        owner[k] <= OWN_FREE;
      dcache_outstanding <= 4'd0;
      icache_outstanding <= 4'd0;
      pref_outstanding   <= 4'd0;
    end else begin
      if (retire_owner != OWN_FREE)
        owner[mem2proc_tag] <= OWN_FREE;
      if (alloc)
        owner[mem2proc_response] <= grant;
      dcache_outstanding <= next_count(dcache_outstanding,
                                       alloc && (grant == OWN_DCACHE),
                                       retire_owner == OWN_DCACHE);
      icache_outstanding <= next_count(icache_outstanding,
                                       alloc && (grant == OWN_ICACHE),
                                       retire_owner == OWN_ICACHE);
      pref_outstanding   <= next_count(pref_outstanding,
                                       alloc && (grant == OWN_PREF),
                                       retire_owner == OWN_PREF);
    end
  end

endmodule

// File: tb/tb_mem_switch.sv
// Directed bench for mem_switch: a tag-ownership model checks every output each
// cycle, and literal expectations pin the scenarios from the test plan.
module tb_mem_switch;
  import mem_switch_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      d_cmd, i_cmd, p_cmd;
  logic [XLEN-1:0] d_addr, i_addr, p_addr;
  logic [63:0]     d_data, m_data;
  logic [3:0]      resp, tag;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data, mem2cache_data;
  logic [3:0]      d_resp, i_resp, p_resp, d_tag, i_tag, p_tag;
  logic [3:0]      d_out, i_out, p_out;
  logic            give_way;

  int assertCount = 0;
  int failCount = 0;
  logic checkEnable = 1'b0;

  // Model state: owner of each tag (0 free, 1 dcache, 2 icache, 3 prefetch), loads in flight
  int modelOwner [16];
  int modelCount [4];

  always #5 clock = ~clock;

  mem_switch dut (
    .clock(clock), .reset(reset),
    .dcache2mem_command(d_cmd), .dcache2mem_addr(d_addr), .dcache2mem_data(d_data),
    .icache2mem_command(i_cmd), .icache2mem_addr(i_addr),
    .pref2mem_command(p_cmd), .pref2mem_addr(p_addr),
    .mem2proc_response(resp), .mem2proc_tag(tag), .mem2proc_data(m_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2dcache_response(d_resp), .mem2icache_response(i_resp), .mem2pref_response(p_resp),
    .mem2dcache_tag(d_tag), .mem2icache_tag(i_tag), .mem2pref_tag(p_tag),
    .mem2cache_data(mem2cache_data), .give_way(give_way),
    .dcache_outstanding(d_out), .icache_outstanding(i_out), .pref_outstanding(p_out)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic [1:0] dc, input logic [XLEN-1:0] da, input logic [63:0] dd,
                               input logic [1:0] ic, input logic [XLEN-1:0] ia,
                               input logic [1:0] pc, input logic [XLEN-1:0] pa,
                               input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] md);
    @(posedge clock);
    #1;
    reset = rst;
    d_cmd = dc; d_addr = da; d_data = dd;
    i_cmd = ic; i_addr = ia;
    p_cmd = pc; p_addr = pa;
    resp = rsp; tag = tg; m_data = md;
    @(negedge clock);
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, BUS_NONE, 0, 0, BUS_NONE, 0, BUS_NONE, 0, 4'd0, 4'd0, 64'd0);
  endtask

  // Which requester the rules pick: first non-idle of dcache, icache, prefetch
  function automatic int winner();
    if (d_cmd != BUS_NONE) return 1;
    if (i_cmd != BUS_NONE) return 2;
    if (p_cmd != BUS_NONE) return 3;
    return 0;
  endfunction

  always @(posedge clock) begin
    int w;
    int o;
    logic [1:0] wcmd;
    if (reset) begin
      foreach (modelOwner[k]) modelOwner[k] = 0;
      foreach (modelCount[k]) modelCount[k] = 0;
    end else begin
      w = winner();
      wcmd = (w == 1) ? d_cmd : (w == 2) ? i_cmd : (w == 3) ? p_cmd : BUS_NONE;
      if (tag != 0) begin
        o = modelOwner[tag];
        if (o != 0) begin
          if (modelCount[o] > 0) modelCount[o]--;
          modelOwner[tag] = 0;
        end
      end
      if (w != 0 && wcmd == BUS_LOAD && resp != 0) begin
        modelOwner[resp] = w;
        modelCount[w]++;
      end
    end
  end

  always @(negedge clock) begin
    int w;
    int o;
    logic [1:0] ecmd;
    logic [XLEN-1:0] eaddr;
    logic [63:0] edata;
    if (checkEnable) begin
      w = winner();
      ecmd = BUS_NONE; eaddr = '0; edata = '0;
      case (w)
        1: begin ecmd = d_cmd; eaddr = d_addr; edata = d_data; end
        2: begin ecmd = i_cmd; eaddr = i_addr; end
        3: begin ecmd = p_cmd; eaddr = p_addr; end
        default: ;
      endcase
      o = (tag != 0) ? modelOwner[tag] : 0;
      checkOutput("model.command", proc2mem_command, ecmd);
      checkOutput("model.addr", proc2mem_addr, eaddr);
      checkOutput("model.data", proc2mem_data, edata);
      checkOutput("model.d_resp", d_resp, (w == 1) ? resp : 4'd0);
      checkOutput("model.i_resp", i_resp, (w == 2) ? resp : 4'd0);
      checkOutput("model.p_resp", p_resp, (w == 3) ? resp : 4'd0);
      checkOutput("model.d_tag", d_tag, (o == 1) ? tag : 4'd0);
      checkOutput("model.i_tag", i_tag, (o == 2) ? tag : 4'd0);
      checkOutput("model.p_tag", p_tag, (o == 3) ? tag : 4'd0);
      checkOutput("model.cache_data", mem2cache_data, m_data);
      checkOutput("model.give_way", give_way, (p_cmd != BUS_NONE) && (w == 1 || w == 2));
      checkOutput("model.d_out", d_out, modelCount[1]);
      checkOutput("model.i_out", i_out, modelCount[2]);
      checkOutput("model.p_out", p_out, modelCount[3]);
    end
  end

  initial begin
    reset = 1'b1;
    d_cmd = BUS_NONE; i_cmd = BUS_NONE; p_cmd = BUS_NONE;
    d_addr = '0; i_addr = '0; p_addr = '0; d_data = '0; m_data = '0;
    resp = '0; tag = '0;
    idle(1'b1);
    checkEnable = 1'b1;
    idle(1'b1);

    // Reset state
    idle(1'b0);
    checkOutput("reset.command", proc2mem_command, BUS_NONE);
    checkOutput("reset.addr", proc2mem_addr, 0);
    checkOutput("reset.tags", {d_tag, i_tag, p_tag}, 0);
    checkOutput("reset.counts", {d_out, i_out, p_out}, 0);
    checkOutput("reset.give_way", give_way, 0);

    // Single icache load, tag returns three cycles later
    applyStimulus(0, BUS_NONE, 0, 0, BUS_LOAD, 'h100, BUS_NONE, 0, 4'd5, 4'd0, 64'd0);
    checkOutput("single.addr", proc2mem_addr, 'h100);
    checkOutput("single.i_resp", i_resp, 5);
    idle(1'b0);
    checkOutput("single.i_out", i_out, 1);
    idle(1'b0);
    applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, BUS_NONE, 0, 4'd0, 4'd5, 64'h1234_5678_9abc_def0);
    checkOutput("single.i_tag", i_tag, 5);
    checkOutput("single.other_tags", {d_tag, p_tag}, 0);
    checkOutput("single.bcast", mem2cache_data, 64'h1234_5678_9abc_def0);
    idle(1'b0);
    checkOutput("single.i_out_after", i_out, 0);

    // Three-way contention
    applyStimulus(0, BUS_LOAD, 'h200, 0, BUS_LOAD, 'h100, BUS_LOAD, 'h108, 4'd3, 4'd0, 64'd0);
    checkOutput("contend.addr", proc2mem_addr, 'h200);
    checkOutput("contend.d_resp", d_resp, 3);
    checkOutput("contend.losers", {i_resp, p_resp}, 0);
    checkOutput("contend.give_way", give_way, 1);
    applyStimulus(0, BUS_NONE, 0, 0, BUS_LOAD, 'h100, BUS_LOAD, 'h108, 4'd0, 4'd3, 64'd0);
    checkOutput("contend2.addr", proc2mem_addr, 'h100);
    checkOutput("contend2.give_way", give_way, 1);
    checkOutput("contend2.d_tag", d_tag, 3);
    idle(1'b0);
    checkOutput("contend.d_out", d_out, 0);

    // Prefetch alone, rejected by memory
    applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, BUS_LOAD, 'h300, 4'd0, 4'd0, 64'd0);
    checkOutput("reject.give_way", give_way, 0);
    checkOutput("reject.p_resp", p_resp, 0);
    checkOutput("reject.command", proc2mem_command, BUS_LOAD);
    idle(1'b0);
    checkOutput("reject.p_out", p_out, 0);

    // Store accepted: no allocation, later tag dropped
    applyStimulus(0, BUS_STORE, 'h400, 64'hDEAD, BUS_NONE, 0, BUS_NONE, 0, 4'd7, 4'd0, 64'd0);
    checkOutput("store.data", proc2mem_data, 64'hDEAD);
    checkOutput("store.d_resp", d_resp, 7);
    checkOutput("store.command", proc2mem_command, BUS_STORE);
    idle(1'b0);
    checkOutput("store.d_out", d_out, 0);
    applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, BUS_NONE, 0, 4'd0, 4'd7, 64'd0);
    checkOutput("store.tag_dropped", {d_tag, i_tag, p_tag}, 0);

    // Tag reuse: retire and reallocate tag 4 in the same cycle
    applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, BUS_LOAD, 'h500, 4'd4, 4'd0, 64'd0);
    checkOutput("reuse.p_resp", p_resp, 4);
    idle(1'b0);
    checkOutput("reuse.p_out", p_out, 1);
    applyStimulus(0, BUS_NONE, 0, 0, BUS_LOAD, 'h600, BUS_NONE, 0, 4'd4, 4'd4, 64'd0);
    checkOutput("reuse.p_tag", p_tag, 4);
    checkOutput("reuse.i_resp", i_resp, 4);
    checkOutput("reuse.i_tag", i_tag, 0);
    applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, BUS_NONE, 0, 4'd0, 4'd4, 64'd0);
    checkOutput("reuse.p_out_after", p_out, 0);
    checkOutput("reuse.i_out", i_out, 1);
    checkOutput("reuse.i_tag_now", i_tag, 4);
    checkOutput("reuse.p_tag_now", p_tag, 0);
    idle(1'b0);
    checkOutput("reuse.i_out_after", i_out, 0);

    // Reset with loads in flight
    applyStimulus(0, BUS_LOAD, 'h700, 0, BUS_NONE, 0, BUS_NONE, 0, 4'd2, 4'd0, 64'd0);
    applyStimulus(0, BUS_NONE, 0, 0, BUS_LOAD, 'h800, BUS_NONE, 0, 4'd9, 4'd0, 64'd0);
    idle(1'b0);
    checkOutput("midreset.d_out", d_out, 1);
    checkOutput("midreset.i_out", i_out, 1);
    idle(1'b1);
    applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, BUS_NONE, 0, 4'd0, 4'd2, 64'd0);
    checkOutput("midreset.counts", {d_out, i_out, p_out}, 0);
    checkOutput("midreset.tag2", {d_tag, i_tag, p_tag}, 0);
    applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, BUS_NONE, 0, 4'd0, 4'd9, 64'd0);
    checkOutput("midreset.tag9", {d_tag, i_tag, p_tag}, 0);
    idle(1'b0);

    checkEnable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_switch.md
# mem_switch

Single-port memory arbiter between the data cache, the instruction cache and the instruction prefetcher. It grants the one memory bus to at most one requester per cycle, with fixed priority dcache > icache > prefetch. It records which requester owns each outstanding transaction tag and routes each returning tag only to that requester. It also generates the `give_way` signal the prefetcher uses to retry a lost request.

## Interface
Parameters: none. `XLEN` and `BUS_NONE`/`BUS_LOAD`/`BUS_STORE` come from the global header.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dcache2mem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
- dcache2mem_addr  in  XLEN  dcache request address
- dcache2mem_data  in  64  store data
- icache2mem_command  in  2  BUS_NONE/BUS_LOAD
- icache2mem_addr  in  XLEN  icache request address
- pref2mem_command  in  2  BUS_NONE/BUS_LOAD
- pref2mem_addr  in  XLEN  prefetch request address
- mem2proc_response  in  4  memory accept tag; 0 = reject
- mem2proc_tag  in  4  completing tag; 0 = none
- mem2proc_data  in  64  data for mem2proc_tag
- proc2mem_command  out  2  granted command
- proc2mem_addr  out  XLEN  granted address
- proc2mem_data  out  64  dcache2mem_data when dcache granted, else 0
- mem2dcache_response / mem2icache_response / mem2pref_response  out  4 each  mem2proc_response if that requester is granted, else 0
- mem2dcache_tag / mem2icache_tag / mem2pref_tag  out  4 each  mem2proc_tag if owned by that requester, else 0
- mem2cache_data  out  64  mem2proc_data, broadcast unmodified
- give_way  out  1  prefetch requested but dcache or icache was granted
- dcache_outstanding / icache_outstanding / pref_outstanding  out  4 each  loads in flight per requester

## Operation
- Grant, combinational. The dcache is granted if its command ≠ BUS_NONE. Otherwise the icache is granted if its command ≠ BUS_NONE. Otherwise the prefetcher is granted if its command ≠ BUS_NONE. Otherwise there is no grant and proc2mem_command = BUS_NONE, addr = 0.
- give_way = (pref2mem_command ≠ BUS_NONE) & (dcache or icache granted). A memory reject while the prefetcher holds the grant does not raise give_way; it shows up as mem2pref_response = 0.
- Owner table: 16 entries × 2 bits. Encoding: 0 = free, 1 = dcache, 2 = icache, 3 = prefetch. Entry 0 is never written.
- Allocate: if the granted command is BUS_LOAD and mem2proc_response ≠ 0, then owner[mem2proc_response] ← granted requester at the next edge. A BUS_STORE accept allocates nothing and leaves the counters unchanged.
- Retire: if mem2proc_tag ≠ 0, look up owner[mem2proc_tag] in the registered table. Drive mem2proc_tag on that requester's tag port only, and free the entry at the next edge.
- Tag with owner free: dropped. All three tag ports are 0 and no counter changes.
- Same index retired and allocated in one cycle: allocate wins, and the entry holds the new owner.
- Counters:
  - +1 on allocate, −1 on retire for the owning requester.
  - Allocate and retire for the same requester in one cycle: net 0.
  - Width 4 bits; cannot exceed 15 because there are 15 tags. A decrement at 0 holds 0. That case only arises from a stale tag after reset.

## Timing
- Grant, responses and give_way are purely combinational in the same cycle as the request.
- Tag routing uses table state registered before the current edge. Memory always returns a tag at least 1 cycle after accepting it.
- Reset: owner table all free, all counters 0. With every command at BUS_NONE after reset, every output is 0 except proc2mem_command = BUS_NONE.
- Reset mid-operation: all ownership is lost. Tags returning after reset are dropped, and requesters re-issue.
- No internal state other than the owner table and the counters. Requests are not queued; a loser must hold or re-present its request.

## Test plan
- **Idle, then single load:** reset; icache BUS_LOAD addr 0x100 with response 5 → proc2mem_addr = 0x100, mem2icache_response = 5, icache_outstanding = 1 next cycle. Three cycles later, tag 5 → mem2icache_tag = 5, other tag ports 0, icache_outstanding = 0.
- **Three-way contention:** dcache LOAD 0x200, icache LOAD 0x100, prefetch LOAD 0x108, response 3 → dcache granted, mem2icache_response = mem2pref_response = 0, give_way = 1. Next cycle, dcache idle → icache granted, give_way = 1.
- **Prefetch reject:** only the prefetcher requests, response 0 → give_way = 0, mem2pref_response = 0, no allocation, pref_outstanding unchanged.
- **Store:** dcache BUS_STORE data 0xDEAD, response 7 → proc2mem_data = 0xDEAD, mem2dcache_response = 7, dcache_outstanding stays 0. A later tag 7 is dropped.
- **Tag reuse:** prefetch owns tag 4. In one cycle, tag 4 returns and the icache is accepted with response 4 → mem2pref_tag = 4 and pref_outstanding decrements. Next cycle owner[4] = icache, so tag 4 routes to the icache.
- **Reset mid-flight:** dcache owns tag 2 and icache owns tag 9; assert reset 1 cycle → counters 0. Subsequent tags 2 and 9 → all tag ports 0.
